mem_port_arbiter: RTL

//  Shares one single-port unified memory between three requesters: debug loader (dbg),
//  CPU data port (d) and CPU instruction fetch (i). The SCPU memory-bus shell uses it
//  for loads/stores and fetch. It drives cpu_stall while a CPU access is outstanding.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for debug loader, CPU data and CPU fetch
// Ports: dbg_*/d_* read/write requesters, i_* read-only fetch requester, *_done one-cycle
// completion pulses, rdata last read word, cpu_stall while a CPU access is pending,
// mem_* strobe/write/byte-enable/address/data towards the memory, mem_rdata MEM_LAT later.
module mem_port_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [3:0]        dbg_be,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [31:0]       rdata,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] OWN_DBG    = 2'd0;
    localparam logic [1:0] OWN_D      = 2'd1;
    localparam logic [1:0] OWN_I      = 2'd2;
    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    logic [1:0] owner;
    logic       ownerRead;
    logic [3:0] latCnt;
    logic [3:0] starveCnt;

    // Fetch jumps the queue once it has lost STARVE_LIMIT decisions in a row.
    logic promoteI;
    logic grantDbg;
    logic grantD;
    logic grantI;

    assign promoteI = i_req && (starveCnt == STARVE_MAX);
    assign grantDbg = dbg_req && !promoteI;
    assign grantD   = d_req && !dbg_req && !promoteI;
    assign grantI   = i_req && (promoteI || (!dbg_req && !d_req));

    assign cpu_stall = (i_req & ~i_done) | (d_req & ~d_done);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_DBG;
            ownerRead <= 1'b0;
            latCnt    <= 4'd0;
            starveCnt <= 4'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            rdata     <= 32'd0;
            dbg_done  <= 1'b0;
            d_done    <= 1'b0;
            i_done    <= 1'b0;
        end else begin
            dbg_done <= 1'b0;
            d_done   <= 1'b0;
            i_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantI) begin
                        owner     <= OWN_I;
                        ownerRead <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'hF;
                        mem_addr  <= i_addr;
                        mem_wdata <= 32'd0;
                        starveCnt <= 4'd0;
                    end else if (grantDbg) begin
                        owner     <= OWN_DBG;
                        ownerRead <= !dbg_we;
                        mem_we    <= dbg_we;
                        mem_be    <= dbg_be;
                        mem_addr  <= dbg_addr;
                        mem_wdata <= dbg_wdata;
                    end else if (grantD) begin
                        owner     <= OWN_D;
                        ownerRead <= !d_we;
                        mem_we    <= d_we;
                        mem_be    <= d_be;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                    // Fetch was asking but someone else won this decision.
                    if (i_req && !grantI && starveCnt != STARVE_MAX) begin
                        starveCnt <= starveCnt + 4'd1;
                    end
                    if (grantDbg || grantD || grantI) begin
                        mem_en <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    latCnt <= LAT_INIT;
                    state  <= WAIT;
                end
                WAIT: begin
                    latCnt <= latCnt - 4'd1;
                    if (latCnt == 4'd1) begin
                        if (ownerRead) begin
                            rdata <= mem_rdata;
                        end
                        case (owner)
                            OWN_DBG: dbg_done <= 1'b1;
                            OWN_D:   d_done   <= 1'b1;
                            default: i_done   <= 1'b1;
                        endcase
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
